// File: rtl/cdc_pulse_arbiter_pkg.sv
// Shared state encoding and elaboration helpers for the CDC pulse arbiter
// and its round-robin picker.
package cdc_pulse_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_ACK_LO = 2'd2
    } arb_state_e;

    // Ceiling log2, used at elaboration to size counters and validate TAG_W.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cdc_pulse_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: returns the first set request at or
// above the pointer, wrapping around, together with a valid flag.
module rr_pick
    import cdc_pulse_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int TAG_W = 2
) (
    input  logic [N-1:0]     req_vec,
    input  logic [TAG_W-1:0] ptr,
    output logic             valid,
    output logic [TAG_W-1:0] idx
);

    localparam int SUM_W = TAG_W + 1;

    logic [2*N-1:0]   req_twice;
    logic [N-1:0]     rotated;
    logic [SUM_W-1:0] ptr_ext;
    logic [TAG_W-1:0] offset;
    logic [SUM_W-1:0] sum;

    if (TAG_W != clog2(N)) begin : g_bad_tag_w
        $error("rr_pick: TAG_W must equal clog2(N)");
    end

    // Rotating through a doubled copy puts the pointer position at bit 0.
    assign req_twice = {req_vec, req_vec};
    assign ptr_ext   = {1'b0, ptr};
    assign rotated   = req_twice[ptr_ext +: N];

    always_comb begin
        valid  = 1'b0;
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                valid  = 1'b1;
                offset = TAG_W'(i);
            end
        end
    end

    always_comb begin
        sum = ptr_ext + {1'b0, offset};
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
    end

    assign idx = sum[TAG_W-1:0];

endmodule

// File: rtl/cdc_pulse_arbiter.sv
// Shares one four-phase CDC pulse channel between N requesters: latches request
// pulses, grants round-robin, and runs the req/ack handshake with a stable tag.
module cdc_pulse_arbiter
    import cdc_pulse_arbiter_pkg::*;
#(
    parameter int N           = 4,
    parameter int TAG_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             sync_ack,
    output logic             sync_req,
    output logic [TAG_W-1:0] grant_tag,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     done,
    output logic [N-1:0]     overflow,
    output logic             timeout,
    output logic             busy
);

    localparam int               CNT_W      = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

    if (TAG_W != clog2(N)) begin : g_bad_tag_w
        $error("cdc_pulse_arbiter: TAG_W must equal clog2(N)");
    end
    if (N < 2 || N > 16) begin : g_bad_n
        $error("cdc_pulse_arbiter: N must be in 2..16");
    end

    arb_state_e       state_q,     state_d;
    logic [TAG_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [N-1:0]     pending_q,   pending_d;
    logic             sync_req_q,  sync_req_d;
    logic [TAG_W-1:0] grant_tag_q, grant_tag_d;
    logic [N-1:0]     done_q,      done_d;
    logic [N-1:0]     overflow_q,  overflow_d;
    logic             timeout_q,   timeout_d;
    logic             busy_q,      busy_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             abandon_q,   abandon_d;

    logic             pick_valid;
    logic [TAG_W-1:0] pick_idx;
    logic [N-1:0]     grant_vec;

    rr_pick #(
        .N     (N),
        .TAG_W (TAG_W)
    ) u_rr_pick (
        .req_vec (pending_q),
        .ptr     (rr_ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sync_req_d  = sync_req_q;
        grant_tag_d = grant_tag_q;
        cnt_d       = cnt_q;
        abandon_d   = abandon_q;
        done_d      = '0;
        timeout_d   = 1'b0;
        grant_vec   = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // A high ack means the channel has not returned to zero yet.
                if (pick_valid && !sync_ack) begin
                    grant_vec[pick_idx] = 1'b1;
                    grant_tag_d         = pick_idx;
                    sync_req_d          = 1'b1;
                    state_d             = ST_REQ_HI;
                    rr_ptr_d            = (pick_idx == TAG_W'(N - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_REQ_HI: begin
                sync_req_d = 1'b1;
                if (sync_ack) begin
                    sync_req_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_ACK_LO;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    sync_req_d = 1'b0;
                    timeout_d  = 1'b1;
                    abandon_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_ACK_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK_LO: begin
                if (!sync_ack) begin
                    done_d[grant_tag_q] = !abandon_q;
                    abandon_d           = 1'b0;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                sync_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // A request landing on its own grant cycle re-queues rather than overflows.
        pending_d  = (pending_q & ~grant_vec) | req;
        overflow_d = req & pending_q & ~grant_vec;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            sync_req_q  <= 1'b0;
            grant_tag_q <= '0;
            done_q      <= '0;
            overflow_q  <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            abandon_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            sync_req_q  <= sync_req_d;
            grant_tag_q <= grant_tag_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            abandon_q   <= abandon_d;
        end
    end

    assign sync_req  = sync_req_q;
    assign grant_tag = grant_tag_q;
    assign pending   = pending_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Bench for cdc_pulse_arbiter: directed scenarios plus random traffic, all
// checked against a transfer-level model of the pending set and handshake.
module tb_cdc_pulse_arbiter;

    localparam int N     = 4;
    localparam int TAG_W = 2;
    localparam int TMO   = 16;
    localparam int VW    = 1 + TAG_W + 3 * N + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             sync_ack;
    logic             sync_req;
    logic [TAG_W-1:0] grant_tag;
    logic [N-1:0]     pending;
    logic [N-1:0]     done;
    logic [N-1:0]     overflow;
    logic             timeout;
    logic             busy;

    always #5 clk = ~clk;

    cdc_pulse_arbiter #(
        .N           (N),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sync_ack  (sync_ack),
        .sync_req  (sync_req),
        .grant_tag (grant_tag),
        .pending   (pending),
        .done      (done),
        .overflow  (overflow),
        .timeout   (timeout),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Synchronizer stand-in: ack follows req after ack_dly cycles, or is forced.
    int   ack_mode;
    logic ack_force;
    int   ack_dly;
    int   lag;

    // Transfer-level model of the arbiter.
    typedef enum {M_FREE, M_LAUNCHED, M_DRAINING} m_phase_e;
    m_phase_e m_phase;
    bit       m_pend [N];
    bit       m_done [N];
    bit       m_ovf  [N];
    bit       m_to;
    bit       m_abandon;
    int       m_ptr;
    int       m_tag;
    int       m_hi;

    logic [VW-1:0] obs_v;
    logic [VW-1:0] exp_v;

    function automatic logic [VW-1:0] dut_vec();
        return {sync_req, grant_tag, pending, done, overflow, timeout, busy};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0] p, d, o;
        for (int i = 0; i < N; i++) begin
            p[i] = m_pend[i];
            d[i] = m_done[i];
            o[i] = m_ovf[i];
        end
        return {(m_phase == M_LAUNCHED), TAG_W'(m_tag), p, d, o, m_to, (m_phase != M_FREE)};
    endfunction

    task automatic model_reset();
        m_phase   = M_FREE;
        m_ptr     = 0;
        m_tag     = 0;
        m_hi      = 0;
        m_to      = 1'b0;
        m_abandon = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_done[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic a);
        int g;
        g    = -1;
        m_to = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
        end
        case (m_phase)
            M_FREE: begin
                if (!a) begin
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    end
                    if (g >= 0) begin
                        m_tag   = g;
                        m_ptr   = (g + 1) % N;
                        m_hi    = 0;
                        m_phase = M_LAUNCHED;
                    end
                end
            end
            M_LAUNCHED: begin
                if (a) begin
                    m_phase = M_DRAINING;
                end else begin
                    m_hi++;
                    if (TMO > 0 && m_hi == TMO) begin
                        m_to      = 1'b1;
                        m_abandon = 1'b1;
                        m_phase   = M_DRAINING;
                    end
                end
            end
            M_DRAINING: begin
                if (!a) begin
                    if (!m_abandon) m_done[m_tag] = 1'b1;
                    m_abandon = 1'b0;
                    m_phase   = M_FREE;
                end
            end
            default: m_phase = M_FREE;
        endcase
        for (int i = 0; i < N; i++) begin
            m_ovf[i]  = r[i] && m_pend[i] && (i != g);
            m_pend[i] = (m_pend[i] && (i != g)) || r[i];
        end
    endtask

    task automatic tick(input logic [N-1:0] r);
        @(negedge clk);
        if (ack_mode == 0) begin
            if (sync_req !== sync_ack) begin
                lag++;
                if (lag >= ack_dly) begin
                    sync_ack = sync_req;
                    lag      = 0;
                end
            end else begin
                lag = 0;
            end
        end else begin
            sync_ack = ack_force;
        end
        req = r;
        @(posedge clk);
        model_step(r, sync_ack);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req      = '0;
        rst      = 1'b1;
        ack_mode = 0;
        sync_ack = 1'b0;
        lag      = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("[TB] FAIL reset_initial got=%b want=%b", dut_vec(), {VW{1'b0}});
        end
        @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("[TB] FAIL reset_held got=%b want=%b", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_launch();
        int done2, done_other;
        done2 = 0;
        done_other = 0;
        for (int c = 1; c <= 10; c++) begin
            tick((c == 10) ? 4'b0100 : 4'b0000);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL single_pre c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
        end
        total++;
        if (pending !== 4'b0100 || sync_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_latch pending=%b sync_req=%b want 0100/0", pending, sync_req);
        end
        tick('0);
        total++;
        if (sync_req !== 1'b1 || grant_tag !== 2'd2) begin
            bad++;
            $display("[TB] FAIL single_launch sync_req=%b tag=%0d want 1/2", sync_req, grant_tag);
        end
        for (int c = 0; c < 40; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL single_run c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (done[2]) done2++;
            if ((done & 4'b1011) != '0) done_other++;
        end
        total++;
        if (done2 != 1 || done_other != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_done done2=%0d other=%0d busy=%b want 1/0/0", done2, done_other, busy);
        end
    endtask

    task automatic test_all_four();
        int   rises, dones, ovfs;
        int   rise_tag [8];
        logic prev;
        do_reset();
        rises = 0; dones = 0; ovfs = 0;
        tick(4'b1111);
        prev = sync_req;
        for (int c = 0; c < 100; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL all_four c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (sync_req && !prev && rises < 8) begin
                rise_tag[rises] = int'(grant_tag);
                rises++;
            end
            prev = sync_req;
            for (int i = 0; i < N; i++) begin
                if (done[i]) dones++;
                if (overflow[i]) ovfs++;
            end
        end
        total++;
        if (rises != 4 || dones != 4 || ovfs != 0) begin
            bad++;
            $display("[TB] FAIL all_four_counts rises=%0d dones=%0d ovf=%0d want 4/4/0", rises, dones, ovfs);
        end
        for (int k = 0; k < 4 && k < rises; k++) begin
            total++;
            if (rise_tag[k] != k) begin
                bad++;
                $display("[TB] FAIL all_four_order slot=%0d tag=%0d want %0d", k, rise_tag[k], k);
            end
        end
    endtask

    task automatic test_overflow_merge();
        logic [N-1:0] pat [5];
        int   ovf1, rises, last_tag;
        logic prev;
        pat = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
        do_reset();
        ovf1 = 0; rises = 0; last_tag = -1;
        prev = 1'b0;
        for (int c = 0; c < 65; c++) begin
            tick((c < 5) ? pat[c] : 4'b0000);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL overflow_run c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (overflow[1]) ovf1++;
            if (c >= 2 && sync_req && !prev) begin
                rises++;
                last_tag = int'(grant_tag);
            end
            prev = sync_req;
            if (c == 4) begin
                total++;
                if (pending !== 4'b0010) begin
                    bad++;
                    $display("[TB] FAIL overflow_pending got=%b want=0010", pending);
                end
            end
        end
        total++;
        if (ovf1 != 2 || rises != 1 || last_tag != 1) begin
            bad++;
            $display("[TB] FAIL overflow_merge ovf1=%0d rises=%0d tag=%0d want 2/1/1", ovf1, rises, last_tag);
        end
    endtask

    task automatic test_requeue();
        int   rises0, ovfs, done0;
        logic prev;
        do_reset();
        rises0 = 0; ovfs = 0; done0 = 0;
        tick(4'b0001);
        tick(4'b0001);
        total++;
        if (pending !== 4'b0001 || overflow !== 4'b0000 || sync_req !== 1'b1 || grant_tag !== 2'd0) begin
            bad++;
            $display("[TB] FAIL requeue_grant pend=%b ovf=%b sreq=%b tag=%0d want 0001/0000/1/0",
                     pending, overflow, sync_req, grant_tag);
        end
        prev = sync_req;
        for (int c = 0; c < 60; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL requeue_run c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (sync_req && !prev && grant_tag == 2'd0) rises0++;
            prev = sync_req;
            if (overflow != '0) ovfs++;
            if (done[0]) done0++;
        end
        total++;
        if (rises0 != 1 || ovfs != 0 || done0 != 2) begin
            bad++;
            $display("[TB] FAIL requeue_second rises0=%0d ovf=%0d done0=%0d want 1/0/2", rises0, ovfs, done0);
        end
    endtask

    task automatic test_timeout();
        int   hi_cycles, to_cnt, done_cnt, rises, next_tag;
        bit   fell;
        logic prev;
        do_reset();
        ack_mode = 1;
        ack_force = 1'b0;
        hi_cycles = 1; to_cnt = 0; done_cnt = 0; rises = 0; next_tag = -1; fell = 1'b0;
        tick(4'b0110);
        tick('0);
        total++;
        if (sync_req !== 1'b1 || grant_tag !== 2'd1) begin
            bad++;
            $display("[TB] FAIL timeout_launch sreq=%b tag=%0d want 1/1", sync_req, grant_tag);
        end
        prev = sync_req;
        for (int c = 0; c < 40; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL timeout_run c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (!fell) begin
                if (sync_req) hi_cycles++;
                else fell = 1'b1;
            end
            if (timeout) to_cnt++;
            if (done != '0) done_cnt++;
            if (sync_req && !prev) begin
                rises++;
                next_tag = int'(grant_tag);
            end
            prev = sync_req;
        end
        total++;
        if (hi_cycles != TMO || to_cnt != 2 || done_cnt != 0 || rises != 1 || next_tag != 2) begin
            bad++;
            $display("[TB] FAIL timeout_abandon hi=%0d to=%0d done=%0d rises=%0d tag=%0d want %0d/2/0/1/2",
                     hi_cycles, to_cnt, done_cnt, rises, next_tag, TMO);
        end
        ack_mode = 0;
        lag = 0;
        for (int c = 0; c < 10; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL timeout_idle c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        int highs;
        do_reset();
        highs = 0;
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b0010);
        obs_v = dut_vec(); exp_v = model_vec(); total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("[TB] FAIL midreset_setup got=%b want=%b", obs_v, exp_v);
        end
        @(negedge clk);
        ack_mode  = 1;
        ack_force = 1'b1;
        sync_ack  = 1'b1;
        req       = '0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_async got=%b want=%b", dut_vec(), {VW{1'b0}});
        end
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_hold got=%b want=%b", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b0;
        tick(4'b1000);
        total++;
        if (pending !== 4'b1000 || sync_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_pend pend=%b sreq=%b want 1000/0", pending, sync_req);
        end
        for (int c = 0; c < 4; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL midreset_wait c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
            if (sync_req) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++;
            $display("[TB] FAIL midreset_blocked highs=%0d want 0", highs);
        end
        ack_force = 1'b0;
        tick('0);
        total++;
        if (sync_req !== 1'b1 || grant_tag !== 2'd3) begin
            bad++;
            $display("[TB] FAIL midreset_launch sreq=%b tag=%0d want 1/3", sync_req, grant_tag);
        end
        ack_mode = 0;
        lag = 0;
        for (int c = 0; c < 30; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL midreset_drain c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            ack_dly = int'($urandom_range(20, 1));
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < N; i++) begin
                    r[i] = ($urandom_range(7, 0) == 0);
                end
                tick(r);
                obs_v = dut_vec(); exp_v = model_vec(); total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("[TB] FAIL random blk=%0d c=%0d got=%b want=%b", blk, c, obs_v, exp_v);
                end
            end
        end
        ack_dly = 4;
        for (int c = 0; c < 100; c++) begin
            tick('0);
            obs_v = dut_vec(); exp_v = model_vec(); total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL random_drain c=%0d got=%b want=%b", c, obs_v, exp_v);
            end
        end
        ack_dly = 6;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        sync_ack  = 1'b0;
        ack_mode  = 0;
        ack_force = 1'b0;
        ack_dly   = 6;
        lag       = 0;
        model_reset();
        test_reset();
        test_single_launch();
        test_all_four();
        test_overflow_merge();
        test_requeue();
        test_timeout();
        test_reset_mid_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
